mem_read_port: RTL and testbench
================================

# mem_read_port

Requester-side load unit for the multi-cycle MIPS datapath. It takes a one-cycle load request from the control FSM and drives a ready/ack handshake toward data memory. It captures the returned word, extracts and extends the addressed byte or halfword, and holds the result on `dataOut` until the next load completes. It replaces the free-running capture register on the load path so that variable-latency memory can be used.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles `mem_req` stays high without `mem_ack` before the load is aborted. Legal range is 1..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: load request pulse, sampled only when `busy`=0.
- `addr` input 32: byte address of the load.
- `size` input 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `sign_ext` input 1: 1 = sign-extend byte/halfword, 0 = zero-extend.
- `busy` output 1: high while a load is in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: high when the last load aborted; sticky.
- `dataOut` output 32: last successfully loaded value, held.
- `mem_req` output 1: memory read request.
- `mem_addr` output 32: word-aligned address, equal to {addr[31:2], 2'b00}.
- `mem_ack` input 1: memory read data valid.
- `mem_rdata` input 32: memory read data.

## Operation
- FSM states: IDLE, REQ, DONE, ERR. `busy` = (state != IDLE).
- IDLE, `start`=1: latch `addr`, `size` and `sign_ext`, and clear `err`. Then:
  - illegal `size`, or misaligned address (halfword with addr[0]=1, or word with addr[1:0]≠0) → ERR;
  - otherwise → REQ and clear the timeout counter.
- REQ: `mem_req`=1 and `mem_addr` is held stable.
  - `mem_ack`=1 at an edge: capture and extract `mem_rdata` into `dataOut`, go to DONE.
  - no ack: the counter increments. If no ack has arrived at the edge ending the TIMEOUT-th REQ cycle, go to ERR.
  - An ack at that same edge wins; the load completes normally.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `done`=1 and `err`=1, then IDLE. `err` stays 1 until the next accepted `start`. `dataOut` is unchanged.
- Byte-lane extraction is little-endian:
  - byte k = addr[1:0] uses `mem_rdata`[8k+7:8k];
  - halfword h = addr[1] uses `mem_rdata`[16h+15:16h];
  - extension is by `sign_ext`.
- `start` while `busy`=1 is ignored. It is not queued.
- `mem_ack` outside REQ is ignored.
- All outputs are registered except `busy` and `mem_addr`, which decode directly from registered state.

## Timing
- Reset (async, immediate): state=IDLE, `busy`=0, `done`=0, `err`=0, `mem_req`=0, `dataOut`=0, `mem_addr`=0, counter=0.
- Reset asserted mid-load aborts the load with no `done` pulse. `mem_req` drops asynchronously.
- `start` sampled at edge E0: `mem_req` and `busy` are high after E0.
- First ack sampled at edge Ek (k ≥ 1): `dataOut` updates and `done`=1 after Ek. `busy` and `done` fall after Ek+1.
- Minimum latency (ack in the first REQ cycle): `done` appears 2 cycles after `start`.
- Misaligned load: `done`=`err`=1 in the cycle after E0, and `mem_req` never rises.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, and `done`/`err` are high in the following cycle.
- A new `start` is accepted at the edge where `busy` is already 0, i.e. one cycle after `done`.

## Test plan
- Word load: addr=0x100, size=10, `mem_rdata`=0xDEADBEEF, ack 3 cycles after `mem_req` rises → `mem_addr`=0x100, `dataOut`=0xDEADBEEF, single `done` pulse, `err`=0.
- Signed byte: addr=0x203, sign_ext=1, `mem_rdata`=0x80123456, immediate ack → `dataOut`=0xFFFFFF80. Repeat with sign_ext=0 → 0x00000080.
- Halfword: addr=0x302, sign_ext=0, `mem_rdata`=0xBEEF1234 → `dataOut`=0x0000BEEF. addr=0x301 → `err`=1, no `mem_req`, `dataOut` keeps 0x0000BEEF.
- Timeout with TIMEOUT=4 and no ack → `mem_req` high for exactly 4 cycles, then `done`=`err`=1. Ack exactly at the 4th edge → normal completion with `err`=0.
- `start` pulsed while `busy` → ignored, only one `mem_req` burst. Next `start` after `done` clears a sticky `err`.
- `rst_n` low in the middle of REQ → all outputs are 0 immediately, and no `done` follows deassertion.

Source files
------------

// File: rtl/mem_read_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_port
// Description : Requester-side load unit for the multi-cycle MIPS datapath.
//               Accepts a one-cycle load request, runs a req/ack handshake
//               toward data memory, extracts and extends the addressed
//               byte/halfword/word and holds it on dataOut. Misaligned or
//               illegal requests and memory timeouts abort with a sticky err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    : max REQ cycles without mem_ack before abort (1..255)
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : load request pulse, sampled only while idle
//   addr       : byte address of the load
//   size       : 00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext   : 1 sign-extend, 0 zero-extend sub-word loads
//   busy       : load in progress
//   done       : one-cycle completion pulse (success or abort)
//   err        : last load aborted (sticky until next accepted start)
//   dataOut    : last successfully loaded value
//   mem_req    : memory read request
//   mem_addr   : word-aligned memory address
//   mem_ack    : memory read data valid
//   mem_rdata  : memory read data
// ============================================================================
module mem_read_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] dataOut,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Counter value seen during the TIMEOUT-th REQ cycle (counter starts at 0).
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic [31:0] data_q, data_d;

    logic        bad_req;
    logic        accept;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;

    // Alignment/legality check uses the live request inputs so the abort
    // decision is made on the accepting edge.
    always_comb begin
        bad_req = 1'b0;
        case (size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = addr[0];
            2'b10:   bad_req = (addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    assign accept = (state_q == S_IDLE) && start;

    // Little-endian lane selection from the latched request.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{sext_q & sel_half[15]}}, sel_half};
            default: load_val = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = bad_req ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the timeout edge still completes normally.
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        size_d = size_q;
        sext_d = sext_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        err_d  = err_q;
        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE) || (state_d == S_ERR);

        if (accept) begin
            addr_d = addr;
            size_d = size;
            sext_d = sign_ext;
            err_d  = 1'b0;
        end

        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == S_REQ) begin
            cnt_d = cnt_q + 8'd1;
            if (mem_ack) begin
                data_d = load_val;
            end
        end

        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 32'd0;
            size_q <= 2'd0;
            sext_q <= 1'b0;
            cnt_q  <= 8'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            size_q <= size_d;
            sext_q <= sext_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            err_q  <= err_d;
            req_q  <= req_d;
            done_q <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_req  = req_q;
    assign done     = done_q;
    assign err      = err_q;
    assign dataOut  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_port
// Description : Directed self-checking bench for mem_read_port (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_port;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] dataOut;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total;
    int bad;

    mem_read_port #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .addr     (addr),
        .size     (size),
        .sign_ext (sign_ext),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dataOut  (dataOut),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one load and plays the memory side: acks in REQ cycle waits+1
    // when give_ack is set. Records what the DUT showed until it goes idle.
    task automatic run_load(input logic [31:0] a, input logic [1:0] s,
                            input logic se, input logic [31:0] rd,
                            input int waits, input bit give_ack,
                            output int req_cyc, output int done_cyc,
                            output logic err_seen, output logic [31:0] addr_seen,
                            output bit finished);
        req_cyc   = 0;
        done_cyc  = 0;
        err_seen  = 1'b0;
        addr_seen = 32'hxxxx_xxxx;
        finished  = 1'b0;
        mem_rdata = rd;
        addr = a; size = s; sign_ext = se; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req) begin
                req_cyc++;
                addr_seen = mem_addr;
            end
            if (done) begin
                done_cyc++;
                err_seen = err;
            end
            mem_ack = give_ack && mem_req && (req_cyc == waits + 1);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy, done, err, mem_req} !== 4'b0000 || dataOut !== 32'd0 || mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b err=%b req=%b data=%h maddr=%h required all zero",
                     busy, done, err, mem_req, dataOut, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word();
        int rc, dc; logic e; logic [31:0] ma; bit fin;
        run_load(32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 2, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (!fin || rc !== 3 || dc !== 1 || e !== 1'b0 || ma !== 32'h100) begin
            bad++;
            $display("FAIL word_hs: fin=%0d req=%0d done=%0d err=%b maddr=%h required 1/3/1/0/00000100",
                     fin, rc, dc, e, ma);
        end
        total++;
        if (dataOut !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL word_data: got %h required DEADBEEF", dataOut);
        end
    endtask

    task automatic test_byte();
        int rc, dc; logic e; logic [31:0] ma; bit fin;
        run_load(32'h203, 2'b00, 1'b1, 32'h80123456, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (!fin || rc !== 1 || dc !== 1 || e !== 1'b0 || ma !== 32'h200 || dataOut !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL byte_signed: fin=%0d req=%0d done=%0d err=%b maddr=%h data=%h required 1/1/1/0/00000200/FFFFFF80",
                     fin, rc, dc, e, ma, dataOut);
        end
        run_load(32'h203, 2'b00, 1'b0, 32'h80123456, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (dataOut !== 32'h00000080) begin
            bad++;
            $display("FAIL byte_zero: got %h required 00000080", dataOut);
        end
        run_load(32'h201, 2'b00, 1'b1, 32'h80123456, 1, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (dataOut !== 32'h00000034) begin
            bad++;
            $display("FAIL byte_lane1: got %h required 00000034", dataOut);
        end
    endtask

    task automatic test_half();
        int rc, dc; logic e; logic [31:0] ma; bit fin;
        run_load(32'h300, 2'b01, 1'b1, 32'h1234_9234, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (dataOut !== 32'hFFFF9234) begin
            bad++;
            $display("FAIL half_signed_lo: got %h required FFFF9234", dataOut);
        end
        run_load(32'h302, 2'b01, 1'b0, 32'hBEEF1234, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (dataOut !== 32'h0000BEEF || ma !== 32'h300) begin
            bad++;
            $display("FAIL half_zero_hi: data=%h maddr=%h required 0000BEEF/00000300", dataOut, ma);
        end
        run_load(32'h301, 2'b01, 1'b0, 32'hCAFECAFE, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (!fin || rc !== 0 || dc !== 1 || e !== 1'b1 || err !== 1'b1 || dataOut !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL half_misalign: fin=%0d req=%0d done=%0d err_at_done=%b err=%b data=%h required 1/0/1/1/1/0000BEEF",
                     fin, rc, dc, e, err, dataOut);
        end
        run_load(32'h400, 2'b11, 1'b0, 32'hCAFECAFE, 0, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (rc !== 0 || dc !== 1 || e !== 1'b1 || dataOut !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL size_illegal: req=%0d done=%0d err=%b data=%h required 0/1/1/0000BEEF", rc, dc, e, dataOut);
        end
    endtask

    task automatic test_timeout();
        int rc, dc; logic e; logic [31:0] ma; bit fin;
        run_load(32'h500, 2'b10, 1'b0, 32'h11112222, 0, 1'b0, rc, dc, e, ma, fin);
        total++;
        if (!fin || rc !== 4 || dc !== 1 || e !== 1'b1 || dataOut !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL timeout: fin=%0d req=%0d done=%0d err=%b data=%h required 1/4/1/1/0000BEEF",
                     fin, rc, dc, e, dataOut);
        end
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        run_load(32'h504, 2'b10, 1'b0, 32'h33334444, 3, 1'b1, rc, dc, e, ma, fin);
        total++;
        if (!fin || rc !== 4 || dc !== 1 || e !== 1'b0 || err !== 1'b0 || dataOut !== 32'h33334444) begin
            bad++;
            $display("FAIL ack_at_limit: fin=%0d req=%0d done=%0d err=%b data=%h required 1/4/1/0/33334444",
                     fin, rc, dc, e, dataOut);
        end
    endtask

    task automatic test_back_to_back();
        int rises;
        logic prev;
        rises = 0;
        prev  = mem_req;
        mem_rdata = 32'h55667788;
        addr = 32'h600; size = 2'b10; sign_ext = 1'b0; start = 1'b1;
        tick();
        addr = 32'h700;
        for (int i = 0; i < 8; i++) begin
            if (mem_req && !prev) rises++;
            prev = mem_req;
            total++;
            if (mem_req && mem_addr !== 32'h600) begin
                bad++;
                $display("FAIL busy_addr_hold: maddr=%h required 00000600", mem_addr);
            end
            mem_ack = (i == 2) && mem_req;
            if (i == 3) start = 1'b0;
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if (rises !== 1 || busy !== 1'b0 || dataOut !== 32'h55667788) begin
            bad++;
            $display("FAIL busy_ignore: req_bursts=%0d busy=%b data=%h required 1/0/55667788", rises, busy, dataOut);
        end
        // Ack while idle must be ignored.
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        tick();
        mem_ack = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || dataOut !== 32'h55667788) begin
            bad++;
            $display("FAIL idle_ack: done=%b busy=%b data=%h required 0/0/55667788", done, busy, dataOut);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        addr = 32'h800; size = 2'b10; sign_ext = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, mem_req} !== 4'b0000 || dataOut !== 32'd0 || mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: busy=%b done=%b err=%b req=%b data=%h maddr=%h required all zero",
                     busy, done, err, mem_req, dataOut, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) dones++;
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_no_done: active_cycles=%0d required 0", dones);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b1;
        start = 1'b0;
        addr = 32'd0;
        size = 2'b00;
        sign_ext = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
